// File: rtl/dpram_bank_if.sv
// Bus bundle for dpram_bank: write port, read port and init status.
`timescale 1ns/1ps
interface dpram_bank_if #(
    parameter int unsigned ASIZE = 4,
    parameter int unsigned DSIZE = 32,
    parameter int unsigned BSIZE = 8
);
    localparam int unsigned NBE = DSIZE / BSIZE;

    logic             wen;
    logic [NBE-1:0]   wbe;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic             ren;
    logic [ASIZE-1:0] raddr;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             init_done;
    logic             wr_drop;

    modport master (
        output wen, wbe, waddr, wdata, ren, raddr,
        input  rdata, rvalid, init_done, wr_drop
    );

    modport slave (
        input  wen, wbe, waddr, wdata, ren, raddr,
        output rdata, rvalid, init_done, wr_drop
    );
endinterface

// File: rtl/dpram_bank.sv
// dpram_bank: dual-clock byte-enabled storage bank, registered read, post-reset clear sequencer.
// Define DPRAM_BANK_OUTREG_EN for a second rclk output register (read latency 2).
`timescale 1ns/1ps
module dpram_bank #(
    parameter int unsigned ASIZE = 4,
    parameter int unsigned DSIZE = 32,
    parameter int unsigned BSIZE = 8
) (
    input  logic        wclk,
    input  logic        rclk,
    input  logic        rst_n,
    dpram_bank_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned NBE   = DSIZE / BSIZE;

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e           state_q, state_d;
    logic [ASIZE-1:0] clr_addr_q, clr_addr_d;
    logic             wr_drop_q, wr_drop_d;

    logic [DSIZE-1:0] mem [DEPTH];
    logic             mem_we;
    logic [ASIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [NBE-1:0]   mem_be;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            clr_addr_q <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // The clear pass shares the single write port; user writes get it only in READY.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_drop_d  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = bus.waddr;
        mem_wdata  = bus.wdata;
        mem_be     = bus.wbe;
        unique case (state_q)
            S_INIT: begin
                mem_we     = rst_n;
                mem_addr   = clr_addr_q;
                mem_wdata  = '0;
                mem_be     = '1;
                clr_addr_d = clr_addr_q + ASIZE'(1);
                wr_drop_d  = bus.wen;
                if (clr_addr_q == ASIZE'(DEPTH - 1)) state_d = S_READY;
            end
            S_READY: begin
                mem_we = bus.wen;
            end
            default: state_d = S_INIT;
        endcase
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge wclk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < NBE; k++) begin
                if (mem_be[k]) mem[mem_addr][k*BSIZE +: BSIZE] <= mem_wdata[k*BSIZE +: BSIZE];
            end
        end
    end

    logic [DSIZE-1:0] rdata_arr_q;
    logic             rvalid_arr_q;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_arr_q  <= '0;
            rvalid_arr_q <= 1'b0;
        end else begin
            rvalid_arr_q <= bus.ren;
            if (bus.ren) rdata_arr_q <= mem[bus.raddr];
        end
    end

`ifdef DPRAM_BANK_OUTREG_EN
    logic [DSIZE-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_arr_q;
            if (rvalid_arr_q) rdata_q <= rdata_arr_q;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`else
    assign bus.rdata  = rdata_arr_q;
    assign bus.rvalid = rvalid_arr_q;
`endif

    assign bus.init_done = (state_q == S_READY);
    assign bus.wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_dpram_bank.sv
// Randomised self-checking bench for dpram_bank against an array-based reference model.
`timescale 1ns/1ps
module tb_dpram_bank;
`ifdef DPRAM_BANK_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 16;

    logic wclk = 1'b0, rclk = 1'b0, rst_n = 1'b0;
    logic wclk_t = 1'b0, rclk_t = 1'b0, tie = 1'b0;
    int   tcnt = 0;

    dpram_bank_if #(.ASIZE(4), .DSIZE(32), .BSIZE(8)) bus ();

    dpram_bank #(.ASIZE(4), .DSIZE(32), .BSIZE(8)) dut (
        .wclk  (wclk),
        .rclk  (rclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Both clocks come from one process so tied mode has no derived-clock race.
    always begin
        #1;
        tcnt++;
        if (tcnt % 5 == 0) wclk_t = ~wclk_t;
        if (tcnt % 7 == 0) rclk_t = ~rclk_t;
        wclk = wclk_t;
        rclk = tie ? wclk_t : rclk_t;
    end

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [3:0]  rq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge wclk); #1;
        bus.wen = 1'b1; bus.waddr = a; bus.wdata = d; bus.wbe = be;
        @(posedge wclk); #1;
        bus.wen = 1'b0;
        ref_mem[a] = merge(ref_mem[a], d, be);
        chk("wr_drop_ready", {31'b0, bus.wr_drop}, 32'd0);
    endtask

    task automatic run_reads(input string tag);
        int n = rq.size();
        int idx;
        logic [31:0] last = '0;
        @(posedge rclk); #1;
        bus.ren = 1'b1; bus.raddr = rq[0];
        for (int j = 0; j <= n + LAT - 1; j++) begin
            @(posedge rclk); #1;
            idx = j - (LAT - 1);
            if (idx >= 0 && idx < n) begin
                last = ref_mem[rq[idx]];
                chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
                chk({tag, "_rdata"}, bus.rdata, last);
            end else begin
                chk({tag, "_rvalid_low"}, {31'b0, bus.rvalid}, 32'd0);
                if (idx == n) chk({tag, "_hold"}, bus.rdata, last);
            end
            if (j + 1 < n) bus.raddr = rq[j + 1];
            else bus.ren = 1'b0;
        end
        rq.delete();
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) rq.push_back(4'(a));
        run_reads(tag);
    endtask

    initial begin
        int cnt;
        bus.wen = 1'b0; bus.wbe = '0; bus.waddr = '0; bus.wdata = '0;
        bus.ren = 1'b0; bus.raddr = '0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;

        // Reset values and clear sequence with a dropped write in INIT cycle 2.
        #23;
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        chk("rst_init_done", {31'b0, bus.init_done}, 32'd0);
        chk("rst_wr_drop", {31'b0, bus.wr_drop}, 32'd0);
        @(negedge wclk); rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge wclk); #1;
            chk("init_done_seq", {31'b0, bus.init_done}, {31'b0, i >= 16});
            chk("wr_drop_seq", {31'b0, bus.wr_drop}, {31'b0, i == 2});
            if (i == 1) begin
                bus.wen = 1'b1; bus.wbe = 4'hF; bus.waddr = 4'd5; bus.wdata = $urandom | 32'h1;
            end
            if (i == 2) bus.wen = 1'b0;
        end
        read_all("init_zero");

        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rq.push_back(4'd3);
        run_reads("be_read");
        chk("be_merge", bus.rdata, 32'hDE22BE44);

        for (int a = 0; a < DEPTH; a++) wr(4'(a), 32'(a), 4'hF);
        read_all("b2b");

        for (int i = 0; i < 40; i++)
            wr(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 30; i++) rq.push_back(4'($urandom_range(0, 15)));
        run_reads("rand");

        // Tied clocks: read-before-write on the same edge.
        @(negedge wclk); tie = 1'b1;
        @(posedge wclk); #1;
        bus.wen = 1'b1; bus.waddr = 4'd7; bus.wdata = 32'hA5A5A5A5; bus.wbe = 4'hF;
        @(posedge wclk); #1;
        ref_mem[7] = 32'hA5A5A5A5;
        bus.wdata = 32'h5A5A5A5A; bus.ren = 1'b1; bus.raddr = 4'd7;
        for (int j = 0; j <= LAT; j++) begin
            @(posedge wclk); #1;
            if (j == 0) begin bus.wen = 1'b0; ref_mem[7] = 32'h5A5A5A5A; end
            if (j == 1) bus.ren = 1'b0;
            if (j == LAT - 1) chk("tied_old", bus.rdata, 32'hA5A5A5A5);
            if (j == LAT) chk("tied_new", bus.rdata, 32'h5A5A5A5A);
            if (j >= LAT - 1) chk("tied_rvalid", {31'b0, bus.rvalid}, 32'd1);
        end
        @(negedge wclk); tie = 1'b0;

        // Reset mid-stream after filling every word with ones.
        for (int a = 0; a < DEPTH; a++) wr(4'(a), 32'hFFFFFFFF, 4'hF);
        @(posedge rclk); #1;
        bus.ren = 1'b1; bus.raddr = 4'd0;
        repeat (LAT) @(posedge rclk);
        #1;
        chk("pre_rst_rvalid", {31'b0, bus.rvalid}, 32'd1);
        chk("pre_rst_rdata", bus.rdata, 32'hFFFFFFFF);
        #3; rst_n = 1'b0;
        #1;
        chk("midrst_rdata", bus.rdata, 32'd0);
        chk("midrst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        chk("midrst_init_done", {31'b0, bus.init_done}, 32'd0);
        bus.ren = 1'b0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        #10;
        @(negedge wclk); rst_n = 1'b1;
        cnt = 0;
        while (cnt < 20) begin
            @(posedge wclk); #1;
            cnt++;
            if (bus.init_done) break;
        end
        chk("reinit_cycles", 32'(cnt), 32'd16);
        read_all("reinit_zero");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
